pipeline_ctrl: RTL and testbench
================================

# pipeline_ctrl

Central pipeline sequencer for the five-stage MIPS core. It consumes the hazard unit's stall/redirect decisions and the cache hit signals, and drives the per-latch enable/flush controls for IF/ID, ID/EX, EX/MEM and MEM/WB, plus the PC write strobe. It also owns the halt drain state machine and a set of saturating performance counters read by the testbench and system monitor.

## Interface
- CNT_W, 32, width of each performance counter
- CLK  in  1  system clock, rising edge
- RST  in  1  asynchronous reset, active-high
- ihit  in  1  icache returned the current instruction this cycle
- dhit  in  1  dcache completed the MEM-stage access this cycle
- mem_dREN / mem_dWEN  in  1 each  MEM-stage instruction reads / writes data memory
- mem_valid  in  1  MEM stage holds a real instruction (not a bubble)
- mem_halt  in  1  MEM stage holds a HALT
- hazard  in  1  hazard unit: data hazard in ID, stall front end
- branch, jump  in  1 each  hazard unit: taken branch / jump resolved in ID
- pc_en  out  1  PC register loads next value
- pc_redirect  out  1  PC loads branch/jump target instead of PC+4
- en_ifid, en_idex, en_exmem, en_memwb  out  1 each  latch loads on this edge
- flush_ifid, flush_idex, flush_exmem  out  1 each  latch loads a bubble (only meaningful with its en high; flush wins over data)
- halt  out  1  core halted, sticky until RST
- cyc_cnt, stall_cnt, redir_cnt, ret_cnt  out  CNT_W each  performance counters

## Operation
- FSM states: RUN, DRAIN, HALTED. Reset state RUN.
- mem_wait = (mem_dREN | mem_dWEN) & ~dhit.
- RUN, first matching rule wins (signals not listed are 0; en_* not listed are 1):
  1. mem_wait: every en_* = 0, pc_en = 0. Whole pipe frozen.
  2. mem_halt: en_ifid = en_idex = en_exmem = 0, en_memwb = 1, pc_en = 0. Next state DRAIN.
  3. hazard: pc_en = 0, en_ifid = 0, flush_idex = 1. IF/ID held, bubble into EX.
  4. branch | jump: pc_en = 1, pc_redirect = 1, flush_ifid = 1. ihit is ignored, so a wrong-path fetch in flight is discarded and the next fetch is at the target.
  5. ~ihit: pc_en = 0, flush_ifid = 1. Back end advances and a bubble enters ID.
  6. otherwise: all latches advance, pc_en = 1.
- DRAIN (one cycle): all en_* = 0, pc_en = 0. This cycle lets the HALT's write-back complete. Next state HALTED.
- HALTED: all en_* = 0, pc_en = 0, halt = 1. Remains HALTED until RST.
- Counters (all saturate at 2^CNT_W-1, never wrap):
  - cyc_cnt: +1 every cycle state != HALTED.
  - stall_cnt: +1 every RUN cycle with pc_en = 0.
  - redir_cnt: +1 every cycle pc_redirect = 1.
  - ret_cnt: +1 every cycle en_memwb & mem_valid.
- The control outputs are combinational from state and inputs. State, halt and the counters are registered.

## Timing
- Reset (async assert): state = RUN, halt = 0, all counters = 0. While RST is high, every en_*, flush_* and pc_* output is 0.
- Control outputs respond to inputs in the same cycle; there is no added latency.
- HALT observed in MEM at cycle N (no mem_wait): DRAIN at N+1, halt = 1 from N+2.
- If mem_halt & mem_wait occur together, rule 1 applies and the transition waits for dhit.
- hazard & branch together: hazard wins. The branch re-resolves after the stall clears.
- branch & ~ihit together: the redirect proceeds (rule 4). It is not delayed by the icache.
- RST asserted mid-DRAIN or in HALTED: immediate return to RUN with counters cleared.

## Test plan
- Reset, then 10 cycles with ihit = 1 and no hazards: all en_* = 1, pc_en = 1 every cycle; cyc_cnt = 10, stall_cnt = 0.
- mem_dREN = 1, dhit = 0 for 3 cycles then dhit = 1: all en_* = 0 for 3 cycles, then all = 1; stall_cnt = 3.
- hazard = 1 and branch = 1 in the same cycle: en_ifid = 0, flush_idex = 1, pc_redirect = 0. Drop hazard next cycle: pc_redirect = 1, flush_ifid = 1, redir_cnt = 1.
- jump = 1 with ihit = 0: pc_en = 1, pc_redirect = 1, flush_ifid = 1.
- mem_halt = 1 at cycle N: en_memwb = 1 and other en_* = 0 at N; all en_* = 0 at N+1; halt = 1 from N+2; cyc_cnt is frozen thereafter. Assert RST: halt = 0 and counters = 0 immediately.
- Preload ret_cnt near its maximum with CNT_W = 4, then retire 20 instructions: ret_cnt holds at 15.

Source files
------------

// File: rtl/pipeline_ctrl_if.sv
// Control bundle between the hazard/cache side and the pipeline sequencer.
// The master side supplies the hazard and cache status inputs. The slave side
// (the sequencer) drives the latch controls, halt and the counters.
interface pipeline_ctrl_if #(parameter int CNT_W = 32);
  logic             ihit, dhit;
  logic             mem_dREN, mem_dWEN, mem_valid, mem_halt;
  logic             hazard, branch, jump;
  logic             pc_en, pc_redirect;
  logic             en_ifid, en_idex, en_exmem, en_memwb;
  logic             flush_ifid, flush_idex, flush_exmem;
  logic             halt;
  logic [CNT_W-1:0] cyc_cnt, stall_cnt, redir_cnt, ret_cnt;

  modport master (
    output ihit, dhit, mem_dREN, mem_dWEN, mem_valid, mem_halt, hazard, branch, jump,
    input  pc_en, pc_redirect, en_ifid, en_idex, en_exmem, en_memwb,
           flush_ifid, flush_idex, flush_exmem, halt,
           cyc_cnt, stall_cnt, redir_cnt, ret_cnt
  );

  modport slave (
    input  ihit, dhit, mem_dREN, mem_dWEN, mem_valid, mem_halt, hazard, branch, jump,
    output pc_en, pc_redirect, en_ifid, en_idex, en_exmem, en_memwb,
           flush_ifid, flush_idex, flush_exmem, halt,
           cyc_cnt, stall_cnt, redir_cnt, ret_cnt
  );
endinterface

// File: rtl/pipeline_ctrl.sv
// Central pipeline sequencer for the five-stage core.
// It produces the latch enable/flush controls and the PC strobes combinationally
// from the FSM state and the hazard/cache inputs. It also owns the halt drain
// FSM and four saturating performance counters.
module pipeline_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             RST,
  pipeline_ctrl_if.slave   bus
);
  typedef enum logic [1:0] {RUN = 2'd0, DRAIN = 2'd1, HALTED = 2'd2} state_e;

  localparam int NCNT = 4;
  localparam int C_CYC = 0, C_STALL = 1, C_REDIR = 2, C_RET = 3;

  state_e state_q;
  logic   halt_q;
  logic   mem_wait;

  logic pc_en, pc_redirect;
  logic en_ifid, en_idex, en_exmem, en_memwb;
  logic flush_ifid, flush_idex, flush_exmem;

  logic [NCNT-1:0]            inc;
  logic [NCNT-1:0][CNT_W-1:0] cnt_q, cnt_d;

  assign mem_wait = (bus.mem_dREN | bus.mem_dWEN) & ~bus.dhit;

  // Latch/PC controls: first matching rule wins in RUN; everything frozen otherwise.
  always_comb begin
    pc_en       = 1'b0;
    pc_redirect = 1'b0;
    en_ifid     = 1'b0;
    en_idex     = 1'b0;
    en_exmem    = 1'b0;
    en_memwb    = 1'b0;
    flush_ifid  = 1'b0;
    flush_idex  = 1'b0;
    flush_exmem = 1'b0;
    if (!RST && state_q == RUN) begin
      if (mem_wait) begin
        // whole pipe frozen until the dcache answers
      end else if (bus.mem_halt) begin
        en_memwb = 1'b1;  // only the HALT's write-back moves
      end else begin
        en_ifid  = 1'b1;
        en_idex  = 1'b1;
        en_exmem = 1'b1;
        en_memwb = 1'b1;
        if (bus.hazard) begin
          en_ifid    = 1'b0;
          flush_idex = 1'b1;
        end else if (bus.branch | bus.jump) begin
          // ihit ignored: the wrong-path fetch is discarded anyway
          pc_en       = 1'b1;
          pc_redirect = 1'b1;
          flush_ifid  = 1'b1;
        end else if (!bus.ihit) begin
          flush_ifid = 1'b1;
        end else begin
          pc_en = 1'b1;
        end
      end
    end
  end

  // Halt drain FSM: RUN -> DRAIN on an unblocked HALT, then HALTED until reset.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= RUN;
      halt_q  <= 1'b0;
    end else begin
      case (state_q)
        RUN:     if (!mem_wait && bus.mem_halt) state_q <= DRAIN;
        DRAIN:   begin
                   state_q <= HALTED;
                   halt_q  <= 1'b1;
                 end
        HALTED:  state_q <= HALTED;
        default: state_q <= RUN;
      endcase
    end
  end

  assign inc[C_CYC]   = (state_q != HALTED);
  assign inc[C_STALL] = (state_q == RUN) & ~pc_en;
  assign inc[C_REDIR] = pc_redirect;
  assign inc[C_RET]   = en_memwb & bus.mem_valid;

  // Saturating counters: stick at all-ones instead of wrapping.
  for (genvar g = 0; g < NCNT; g++) begin : g_cnt
    assign cnt_d[g] = (inc[g] && cnt_q[g] != {CNT_W{1'b1}}) ? cnt_q[g] + CNT_W'(1) : cnt_q[g];
  end

  // Counter registers, cleared by reset.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign bus.pc_en       = pc_en;
  assign bus.pc_redirect = pc_redirect;
  assign bus.en_ifid     = en_ifid;
  assign bus.en_idex     = en_idex;
  assign bus.en_exmem    = en_exmem;
  assign bus.en_memwb    = en_memwb;
  assign bus.flush_ifid  = flush_ifid;
  assign bus.flush_idex  = flush_idex;
  assign bus.flush_exmem = flush_exmem;
  assign bus.halt        = halt_q;
  assign bus.cyc_cnt     = cnt_q[C_CYC];
  assign bus.stall_cnt   = cnt_q[C_STALL];
  assign bus.redir_cnt   = cnt_q[C_REDIR];
  assign bus.ret_cnt     = cnt_q[C_RET];
endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: a 32-bit and a 4-bit counter instance share the same
// stimulus. A rule-level model is checked on every negedge, and directed
// scenarios carry hand-computed literal expectations.
module tb_pipeline_ctrl;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic ihit = 0, dhit = 0, mem_dREN = 0, mem_dWEN = 0, mem_valid = 0, mem_halt = 0;
  logic hazard = 0, branch = 0, jump = 0;
  int checks = 0, errors = 0;

  always #5 CLK = ~CLK;

  pipeline_ctrl_if #(.CNT_W(32)) if32 ();
  pipeline_ctrl_if #(.CNT_W(4))  if4  ();

  assign if32.ihit = ihit;  assign if32.dhit = dhit;
  assign if32.mem_dREN = mem_dREN;  assign if32.mem_dWEN = mem_dWEN;
  assign if32.mem_valid = mem_valid;  assign if32.mem_halt = mem_halt;
  assign if32.hazard = hazard;  assign if32.branch = branch;  assign if32.jump = jump;
  assign if4.ihit = ihit;  assign if4.dhit = dhit;
  assign if4.mem_dREN = mem_dREN;  assign if4.mem_dWEN = mem_dWEN;
  assign if4.mem_valid = mem_valid;  assign if4.mem_halt = mem_halt;
  assign if4.hazard = hazard;  assign if4.branch = branch;  assign if4.jump = jump;

  pipeline_ctrl #(.CNT_W(32)) u32 (.CLK(CLK), .RST(RST), .bus(if32));
  pipeline_ctrl #(.CNT_W(4))  u4  (.CLK(CLK), .RST(RST), .bus(if4));

  // ---------------- behavioural model ----------------
  // phase: 0 running, 1 draining, 2 halted
  int     m_phase = 0;
  longint m_cyc = 0, m_stall = 0, m_redir = 0, m_ret = 0;

  // {pc_en, pc_redirect, en_ifid, en_idex, en_exmem, en_memwb, flush_ifid, flush_idex, flush_exmem}
  function automatic logic [8:0] expect_ctrl(int ph);
    if (RST || ph != 0) return 9'b00_0000_000;
    if ((mem_dREN | mem_dWEN) & ~dhit) return 9'b00_0000_000;
    if (mem_halt)                      return 9'b00_0001_000;
    if (hazard)                        return 9'b00_0111_010;
    if (branch | jump)                 return 9'b11_1111_100;
    if (!ihit)                         return 9'b00_1111_100;
    return 9'b10_1111_000;
  endfunction

  function automatic longint satw(longint v, int w);
    longint mx;
    mx = (longint'(1) << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  // Model state advance on each edge, using the inputs held across that edge.
  always @(posedge CLK or posedge RST) begin
    logic [8:0] c;
    if (RST) begin
      m_phase = 0; m_cyc = 0; m_stall = 0; m_redir = 0; m_ret = 0;
    end else begin
      c = expect_ctrl(m_phase);
      if (m_phase != 2)             m_cyc++;
      if (m_phase == 0 && !c[8])    m_stall++;
      if (c[7])                     m_redir++;
      if (c[3] && mem_valid)        m_ret++;
      if (m_phase == 0) begin
        if (mem_halt && !((mem_dREN | mem_dWEN) & ~dhit)) m_phase = 1;
      end else m_phase = 2;
    end
  end

  // Compare process: every negedge, both instances against the model.
  always @(negedge CLK) begin
    logic [8:0] e, g32, g4;
    e   = expect_ctrl(m_phase);
    g32 = {if32.pc_en, if32.pc_redirect, if32.en_ifid, if32.en_idex, if32.en_exmem,
           if32.en_memwb, if32.flush_ifid, if32.flush_idex, if32.flush_exmem};
    g4  = {if4.pc_en, if4.pc_redirect, if4.en_ifid, if4.en_idex, if4.en_exmem,
           if4.en_memwb, if4.flush_ifid, if4.flush_idex, if4.flush_exmem};
    checks++;
    if (g32 !== e || g4 !== e) begin
      errors++;
      $display("FAIL ctrl t=%0t got32=%b got4=%b exp=%b", $time, g32, g4, e);
    end
    checks++;
    if (if32.halt !== (m_phase == 2) || if4.halt !== (m_phase == 2)) begin
      errors++;
      $display("FAIL halt t=%0t got=%b/%b exp=%b", $time, if32.halt, if4.halt, m_phase == 2);
    end
    checks++;
    if (if32.cyc_cnt !== 32'(satw(m_cyc, 32)) || if32.stall_cnt !== 32'(satw(m_stall, 32)) ||
        if32.redir_cnt !== 32'(satw(m_redir, 32)) || if32.ret_cnt !== 32'(satw(m_ret, 32))) begin
      errors++;
      $display("FAIL cnt32 t=%0t got=%0d/%0d/%0d/%0d exp=%0d/%0d/%0d/%0d", $time,
               if32.cyc_cnt, if32.stall_cnt, if32.redir_cnt, if32.ret_cnt,
               m_cyc, m_stall, m_redir, m_ret);
    end
    checks++;
    if (if4.cyc_cnt !== 4'(satw(m_cyc, 4)) || if4.stall_cnt !== 4'(satw(m_stall, 4)) ||
        if4.redir_cnt !== 4'(satw(m_redir, 4)) || if4.ret_cnt !== 4'(satw(m_ret, 4))) begin
      errors++;
      $display("FAIL cnt4 t=%0t got=%0d/%0d/%0d/%0d exp=%0d/%0d/%0d/%0d", $time,
               if4.cyc_cnt, if4.stall_cnt, if4.redir_cnt, if4.ret_cnt,
               satw(m_cyc, 4), satw(m_stall, 4), satw(m_redir, 4), satw(m_ret, 4));
    end
  end

  // ---------------- directed helpers ----------------
  task automatic step();
    @(posedge CLK); #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic lit(string name, longint got, longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  function automatic logic [3:0] ens();
    return {if32.en_ifid, if32.en_idex, if32.en_exmem, if32.en_memwb};
  endfunction

  task automatic clr_in();
    ihit = 0; dhit = 0; mem_dREN = 0; mem_dWEN = 0; mem_valid = 0; mem_halt = 0;
    hazard = 0; branch = 0; jump = 0;
  endtask

  initial begin
    clr_in();
    settle();
    lit("reset_en", ens(), 0);
    lit("reset_pc_en", if32.pc_en, 0);
    lit("reset_cyc", if32.cyc_cnt, 0);
    step(); step();
    RST = 0;

    // free-running fetch
    ihit = 1;
    for (int i = 0; i < 10; i++) begin
      settle();
      lit("run_en", ens(), 4'b1111);
      lit("run_pc_en", if32.pc_en, 1);
      step();
    end
    settle();
    lit("run_cyc", if32.cyc_cnt, 10);
    lit("run_stall", if32.stall_cnt, 0);

    // dcache miss for 3 cycles
    mem_dREN = 1; dhit = 0;
    for (int i = 0; i < 3; i++) begin
      settle();
      lit("dmiss_en", ens(), 0);
      step();
    end
    dhit = 1;
    settle();
    lit("dhit_en", ens(), 4'b1111);
    step();
    settle();
    lit("dmiss_stall", if32.stall_cnt, 3);
    mem_dREN = 0; dhit = 0;

    // hazard beats branch, branch re-resolves afterwards
    hazard = 1; branch = 1;
    settle();
    lit("hzbr_en_ifid", if32.en_ifid, 0);
    lit("hzbr_flush_idex", if32.flush_idex, 1);
    lit("hzbr_redirect", if32.pc_redirect, 0);
    step();
    hazard = 0;
    settle();
    lit("br_redirect", if32.pc_redirect, 1);
    lit("br_flush_ifid", if32.flush_ifid, 1);
    step();
    settle();
    lit("br_redir_cnt", if32.redir_cnt, 1);
    branch = 0;

    // jump with icache miss still redirects
    jump = 1; ihit = 0;
    settle();
    lit("jmp_pc_en", if32.pc_en, 1);
    lit("jmp_redirect", if32.pc_redirect, 1);
    lit("jmp_flush_ifid", if32.flush_ifid, 1);
    step();
    jump = 0; ihit = 1;

    // halt drain
    mem_halt = 1; mem_valid = 1;
    settle();
    lit("halt_n_en", ens(), 4'b0001);
    lit("halt_n_pc_en", if32.pc_en, 0);
    step();
    mem_halt = 0; mem_valid = 0;
    settle();
    lit("drain_en", ens(), 0);
    lit("drain_halt", if32.halt, 0);
    step();
    settle();
    lit("halted_halt", if32.halt, 1);
    repeat (3) step();
    settle();
    lit("halted_cyc", if32.cyc_cnt, 19);
    lit("halted_cyc4", if4.cyc_cnt, 15);
    lit("halted_ret", if32.ret_cnt, 1);
    lit("halted_en", ens(), 0);
    RST = 1;
    settle();
    lit("rst_halt", if32.halt, 0);
    lit("rst_cyc", if32.cyc_cnt, 0);
    lit("rst_ret", if32.ret_cnt, 0);
    step();
    RST = 0;

    // retire 20 instructions: 4-bit counter pins at 15
    ihit = 1; mem_valid = 1;
    repeat (20) step();
    settle();
    lit("ret4_sat", if4.ret_cnt, 15);
    lit("ret32", if32.ret_cnt, 20);

    // randomized phase
    for (int i = 0; i < 3000; i++) begin
      ihit      = ($urandom % 4) != 0;
      mem_dREN  = ($urandom % 5) == 0;
      mem_dWEN  = ($urandom % 8) == 0;
      dhit      = ($urandom % 2) == 0;
      mem_valid = ($urandom % 4) != 0;
      mem_halt  = ($urandom % 60) == 0;
      hazard    = ($urandom % 6) == 0;
      branch    = ($urandom % 8) == 0;
      jump      = ($urandom % 12) == 0;
      RST       = ($urandom % 80) == 0;
      step();
    end
    RST = 0;
    clr_in();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
